// File: rtl/stopwatch_ctrl_if.sv
// Command and display bundle between the user/debounce side and stopwatch_ctrl.
// master: the command source (user logic or bench); slave: the stopwatch controller.
interface stopwatch_ctrl_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] digits;
    logic [15:0] lap_digits;
    logic        lap_valid;
    logic        running;
    logic        tick;
    logic        ovf;

    modport master (
        output start_stop, clear, lap,
        input  digits, lap_digits, lap_valid, running, tick, ovf
    );

    modport slave (
        input  start_stop, clear, lap,
        output digits, lap_digits, lap_valid, running, tick, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: command FSM gating a prescaler that drives a 4-digit
// BCD decade chain (0000-9999), with lap capture and sticky overflow.
//
// state | meaning
// IDLE  | cleared, waiting for start_stop; prescaler held at zero
// RUN   | prescaler advancing, count increments on every tick
// PAUSE | count and prescaler phase frozen; start_stop resumes
// DONE  | saturated at 9999 (WRAP=0 only); only clear leaves it
module stopwatch_ctrl #(
    parameter int unsigned PRESCALE = 10,
    parameter bit          WRAP     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   digits_q, digits_inc;
    logic [15:0]   lap_q;
    logic          lap_valid_q;
    logic          ovf_q;
    logic          tick_c;
    logic          at_max;
    logic          sat_hold;
    logic          carry;

    assign tick_c   = (state_q == RUN) && (pre_cnt == PRE_MAX);
    assign at_max   = (digits_q == 16'h9999);
    // In saturate mode the overflowing tick leaves the count at 9999.
    assign sat_hold = tick_c && at_max && !WRAP;

    // Ripple the increment through the decades; all digits land on one edge.
    always_comb begin
        carry      = tick_c;
        digits_inc = digits_q;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                digits_inc[4*k +: 4] = (digits_q[4*k +: 4] == 4'd9) ? 4'd0
                                       : digits_q[4*k +: 4] + 4'd1;
            end
            carry = carry && (digits_q[4*k +: 4] == 4'd9);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; clear outranks start_stop, overflow outranks pause.
    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sw.start_stop) state_d = RUN;
                RUN: begin
                    if (sat_hold)           state_d = DONE;
                    else if (sw.start_stop) state_d = PAUSE;
                end
                PAUSE:   if (sw.start_stop) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler phase: restarts from IDLE, free-runs in RUN, frozen elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (sw.clear) begin
            pre_cnt <= '0;
        end else if (state_q == IDLE && sw.start_stop) begin
            pre_cnt <= '0;
        end else if (state_q == RUN) begin
            pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
        end
    end

    // Count, overflow flag and lap capture (lap takes the pre-increment value).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q    <= '0;
            ovf_q       <= 1'b0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (sw.clear) begin
            digits_q    <= '0;
            ovf_q       <= 1'b0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            if (tick_c) begin
                if (!sat_hold) digits_q <= digits_inc;
                if (at_max)    ovf_q    <= 1'b1;
            end
            if (sw.lap && state_q != IDLE) begin
                lap_q       <= digits_q;
                lap_valid_q <= 1'b1;
            end
        end
    end

    assign sw.digits     = digits_q;
    assign sw.lap_digits = lap_q;
    assign sw.lap_valid  = lap_valid_q;
    assign sw.running    = (state_q == RUN);
    assign sw.tick       = tick_c;
    assign sw.ovf        = ovf_q;
endmodule
